brick_lookup_scheduler: RTL and testbench
=========================================

Name: brick_lookup_scheduler

Overview:
- Shares one divide-by-12 column decoder and the brick-state array between two requesters: the video renderer (brick present at pixel?) and the ball physics (hit and clear brick).
- Arbitrates one lookup per cycle through a 2-stage pipeline.
- Keeps the brick-present bitmap and the remaining-brick count, and flags level clear.
- Sits between the VGA pixel pipeline, the ball controller and the score/level logic.

Parameters:
ROWS, 8, number of brick rows; row index width is 3.
COLS, 6, number of brick columns; equals the maximum quotient of a 6-bit numerator divided by 12, plus 1.
STARVE_MAX, 3, consecutive denied ball-request cycles before the ball gets priority.
CNT_W, 6, width of bricks_left; must hold ROWS*COLS.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
init  in  1  synchronous level reload: all bricks present, pipeline flushed
vid_req  in  1  video lookup request
vid_x  in  6  video horizontal brick-cell coordinate, divided by 12
vid_row  in  3  video brick row
vid_gnt  out  1  video request accepted this cycle (combinational)
vid_valid  out  1  video result valid
vid_brick  out  1  brick present at the looked-up cell
vid_rem  out  4  vid_x mod 12, offset inside the brick for edge shading
ball_req  in  1  ball lookup request
ball_x  in  6  ball cell coordinate
ball_row  in  3  ball brick row
ball_clear  in  1  with ball_req: clear the brick if it is present
ball_gnt  out  1  ball request accepted this cycle (combinational)
ball_valid  out  1  ball result valid
ball_hit  out  1  brick was present at lookup time
bricks_left  out  CNT_W  bricks remaining
all_clear  out  1  bricks_left == 0

Behaviour:
- Reset and init both:
  - Set the bitmap to all 1s and bricks_left to ROWS*COLS (48).
  - Clear the stage-1 and stage-2 valids and the starvation counter.
  - Force vid_valid, ball_valid, vid_brick, ball_hit and vid_rem to 0, and all_clear to 0.
  - Drive vid_gnt and ball_gnt to 0 in any cycle where reset or init is high.
- Arbitration (combinational, at most one grant per cycle):
  - Default: vid_req wins and ball_gnt=0.
  - The ball wins when ball_req && (!vid_req || starve_cnt == STARVE_MAX).
  - A request is accepted on req && gnt. A requester holds req and its operands until granted.
- Starvation counter:
  - Increments each cycle that ball_req && !ball_gnt, saturating at STARVE_MAX.
  - Clears on ball_gnt or on !ball_req.
- Stage 0 (accept cycle): the granted operand's x drives the shared divider. On the edge, register quotient (3b), remainder (4b), row, requester id and the clear flag into stage 1.
- Stage 1:
  - Read the bitmap at [row][quotient].
  - If the requester is ball, clear is set, and the bit is 1: clear the bit and decrement bricks_left on this edge.
  - Register the read value (pre-clear) into the stage-2 outputs.
- Stage 2:
  - Assert vid_valid or ball_valid for exactly 1 cycle, 2 cycles after acceptance.
  - vid_brick/vid_rem or ball_hit hold their value until the next valid for that requester.
  - At most one valid is high per cycle.
- Ordering/hazard: a request accepted the cycle after a clearing ball request reads the updated bitmap, so there is no stale read. Throughput is 1 lookup per cycle.
- Boundaries:
  - Row >= ROWS gives a result of 0 and no clear.
  - A clear on an absent brick gives ball_hit=0 and no decrement.
  - bricks_left never underflows.
  - all_clear is combinational from bricks_left and rises the cycle after the last clear edge.
- Reset or init mid-operation: in-flight lookups are discarded and no valid is emitted for them.

Test Plan:
- Reset, then idle -> bricks_left=48, all_clear=0, all valids 0, gnts 0 while reset is high.
- vid_req with vid_x=37, vid_row=2 -> vid_gnt the same cycle; 2 cycles later vid_valid=1, vid_brick=1, vid_rem=1 (37=3*12+1).
- Ball clear x=37, row=2 accepted in cycle N, then video lookup of the same cell in cycle N+1 -> ball_hit=1 at N+2, bricks_left=47, vid_brick=0 at N+3; a second ball clear of that cell -> ball_hit=0, bricks_left stays 47.
- vid_req held high continuously with ball_req held high -> ball denied for 3 cycles, granted on the 4th, starvation counter back to 0; video is re-granted the following cycle.
- Clear all 48 cells via back-to-back ball requests -> bricks_left reaches 0 and all_clear=1 one cycle after the last clear edge; then init -> bricks_left=48, all_clear=0, no valids in the following 2 cycles for the flushed requests.

Source files
------------

// File: rtl/brick_lookup_scheduler.sv
// Brick lookup scheduler.
// Two requesters (video renderer and ball physics) share one divide-by-12
// column decoder and the brick bitmap. One lookup is accepted per cycle and
// its result appears two cycles later. Ball lookups may clear the brick they
// hit, which keeps the remaining-brick count and the level-clear flag current.
module brick_lookup_scheduler #(
    parameter int ROWS       = 8,
    parameter int COLS       = 6,
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             vid_req,
    input  logic [5:0]       vid_x,
    input  logic [2:0]       vid_row,
    output logic             vid_gnt,
    output logic             vid_valid,
    output logic             vid_brick,
    output logic [3:0]       vid_rem,
    input  logic             ball_req,
    input  logic [5:0]       ball_x,
    input  logic [2:0]       ball_row,
    input  logic             ball_clear,
    output logic             ball_gnt,
    output logic             ball_valid,
    output logic             ball_hit,
    output logic [CNT_W-1:0] bricks_left,
    output logic             all_clear
);

    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = $clog2(CELLS);
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    // Divide a 6-bit coordinate by 12: returns {quotient[2:0], remainder[3:0]}.
    // The true remainder is below 16, so it equals the low nibble of x minus
    // the low nibble of 12*q, which keeps the subtraction 4 bits wide.
    function automatic logic [6:0] div12(input logic [5:0] x);
        logic [2:0] q;
        logic [3:0] sub;
        if (x >= 6'd60) begin
            q = 3'd5;
        end else if (x >= 6'd48) begin
            q = 3'd4;
        end else if (x >= 6'd36) begin
            q = 3'd3;
        end else if (x >= 6'd24) begin
            q = 3'd2;
        end else if (x >= 6'd12) begin
            q = 3'd1;
        end else begin
            q = 3'd0;
        end
        case (q)
            3'd0:    sub = 4'd0;
            3'd1:    sub = 4'd12;
            3'd2:    sub = 4'd8;
            3'd3:    sub = 4'd4;
            3'd4:    sub = 4'd0;
            3'd5:    sub = 4'd12;
            default: sub = 4'd0;
        endcase
        return {q, x[3:0] - sub};
    endfunction

    logic                flush_s;
    logic                accept_s;
    logic [5:0]          sel_x_s;
    logic [2:0]          sel_row_s;
    logic                sel_clear_s;
    logic [6:0]          div_s;

    logic [SC_W-1:0]     starve_cnt_r;

    logic                s1_valid_r;
    logic                s1_is_ball_r;
    logic                s1_clear_r;
    logic [2:0]          s1_row_r;
    logic [2:0]          s1_quot_r;
    logic [3:0]          s1_rem_r;
    logic [IDX_W-1:0]    s1_idx_s;
    logic                s1_in_range_s;
    logic                s1_bit_s;
    logic                s1_do_clear_s;

    logic [CELLS-1:0]    bitmap_r;
    logic [CNT_W-1:0]    bricks_left_r;

    logic                vid_valid_r;
    logic                vid_brick_r;
    logic [3:0]          vid_rem_r;
    logic                ball_valid_r;
    logic                ball_hit_r;

    assign flush_s  = reset | init;
    assign accept_s = vid_gnt | ball_gnt;

    // Arbitration: video by default, ball when video is idle or the ball has starved.
    always_comb begin
        vid_gnt  = 1'b0;
        ball_gnt = 1'b0;
        if (flush_s) begin
            vid_gnt  = 1'b0;
            ball_gnt = 1'b0;
        end else if (ball_req && (!vid_req || (starve_cnt_r == SC_W'(STARVE_MAX)))) begin
            ball_gnt = 1'b1;
        end else if (vid_req) begin
            vid_gnt = 1'b1;
        end else begin
            vid_gnt  = 1'b0;
            ball_gnt = 1'b0;
        end
    end

    // Stage 0 operand mux feeding the shared divider.
    always_comb begin
        sel_x_s     = vid_x;
        sel_row_s   = vid_row;
        sel_clear_s = 1'b0;
        if (ball_gnt) begin
            sel_x_s     = ball_x;
            sel_row_s   = ball_row;
            sel_clear_s = ball_clear;
        end else begin
            sel_x_s     = vid_x;
            sel_row_s   = vid_row;
            sel_clear_s = 1'b0;
        end
        div_s = div12(sel_x_s);
    end

    // Count consecutive denied ball cycles, saturating at the starvation limit.
    always_ff @(posedge clk) begin
        if (flush_s) begin
            starve_cnt_r <= {SC_W{1'b0}};
        end else if (ball_req && !ball_gnt) begin
            if (starve_cnt_r != SC_W'(STARVE_MAX)) begin
                starve_cnt_r <= starve_cnt_r + SC_W'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= {SC_W{1'b0}};
        end
    end

    // Stage 1 register: capture the decoded cell and requester of the accepted lookup.
    always_ff @(posedge clk) begin
        if (flush_s) begin
            s1_valid_r   <= 1'b0;
            s1_is_ball_r <= 1'b0;
            s1_clear_r   <= 1'b0;
            s1_row_r     <= 3'd0;
            s1_quot_r    <= 3'd0;
            s1_rem_r     <= 4'd0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_is_ball_r <= ball_gnt;
                s1_clear_r   <= sel_clear_s;
                s1_row_r     <= sel_row_s;
                s1_quot_r    <= div_s[6:4];
                s1_rem_r     <= div_s[3:0];
            end else begin
                s1_is_ball_r <= s1_is_ball_r;
                s1_clear_r   <= s1_clear_r;
                s1_row_r     <= s1_row_r;
                s1_quot_r    <= s1_quot_r;
                s1_rem_r     <= s1_rem_r;
            end
        end
    end

    // Stage 1 bitmap read; out-of-range cells read as absent and are never cleared.
    always_comb begin
        s1_idx_s      = IDX_W'(s1_row_r) * IDX_W'(COLS) + IDX_W'(s1_quot_r);
        s1_in_range_s = (int'(s1_row_r) < ROWS) && (int'(s1_quot_r) < COLS);
        if (s1_in_range_s) begin
            s1_bit_s = bitmap_r[s1_idx_s];
        end else begin
            s1_bit_s = 1'b0;
        end
        s1_do_clear_s = s1_valid_r && s1_is_ball_r && s1_clear_r && s1_bit_s;
    end

    // Bitmap and remaining count: reload on reset/init, clear a hit brick otherwise.
    always_ff @(posedge clk) begin
        if (flush_s) begin
            bitmap_r      <= {CELLS{1'b1}};
            bricks_left_r <= CNT_W'(CELLS);
        end else if (s1_do_clear_s) begin
            bitmap_r[s1_idx_s] <= 1'b0;
            if (bricks_left_r != {CNT_W{1'b0}}) begin
                bricks_left_r <= bricks_left_r - CNT_W'(1);
            end else begin
                bricks_left_r <= bricks_left_r;
            end
        end else begin
            bitmap_r      <= bitmap_r;
            bricks_left_r <= bricks_left_r;
        end
    end

    // Stage 2 result registers: one-cycle valid pulse, data held until the next result.
    always_ff @(posedge clk) begin
        if (flush_s) begin
            vid_valid_r  <= 1'b0;
            vid_brick_r  <= 1'b0;
            vid_rem_r    <= 4'd0;
            ball_valid_r <= 1'b0;
            ball_hit_r   <= 1'b0;
        end else begin
            vid_valid_r  <= s1_valid_r && !s1_is_ball_r;
            ball_valid_r <= s1_valid_r && s1_is_ball_r;
            if (s1_valid_r && !s1_is_ball_r) begin
                vid_brick_r <= s1_bit_s;
                vid_rem_r   <= s1_rem_r;
            end else begin
                vid_brick_r <= vid_brick_r;
                vid_rem_r   <= vid_rem_r;
            end
            if (s1_valid_r && s1_is_ball_r) begin
                ball_hit_r <= s1_bit_s;
            end else begin
                ball_hit_r <= ball_hit_r;
            end
        end
    end

    assign vid_valid   = vid_valid_r;
    assign vid_brick   = vid_brick_r;
    assign vid_rem     = vid_rem_r;
    assign ball_valid  = ball_valid_r;
    assign ball_hit    = ball_hit_r;
    assign bricks_left = bricks_left_r;
    assign all_clear   = (bricks_left_r == {CNT_W{1'b0}});

endmodule

// File: tb/tb_brick_lookup_scheduler.sv
// Scoreboard bench for brick_lookup_scheduler. A reference model applies
// lookups in acceptance order on a 2-D brick array and pushes the expected
// result; a negedge monitor pops and compares whenever a valid appears.
module tb_brick_lookup_scheduler;

    logic       clk = 1'b0;
    logic       reset, init;
    logic       vid_req, ball_req, ball_clear;
    logic [5:0] vid_x, ball_x;
    logic [2:0] vid_row, ball_row;
    logic       vid_gnt, vid_valid, vid_brick, ball_gnt, ball_valid, ball_hit;
    logic [3:0] vid_rem;
    logic [5:0] bricks_left;
    logic       all_clear;

    brick_lookup_scheduler dut (
        .clk(clk), .reset(reset), .init(init),
        .vid_req(vid_req), .vid_x(vid_x), .vid_row(vid_row), .vid_gnt(vid_gnt),
        .vid_valid(vid_valid), .vid_brick(vid_brick), .vid_rem(vid_rem),
        .ball_req(ball_req), .ball_x(ball_x), .ball_row(ball_row), .ball_clear(ball_clear),
        .ball_gnt(ball_gnt), .ball_valid(ball_valid), .ball_hit(ball_hit),
        .bricks_left(bricks_left), .all_clear(all_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        int acc;
        bit is_ball;
        bit hit;
        int rem;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    bit   model_map [8][6];
    int   model_cnt;
    int   model_starve;
    bit   exp_vgnt, exp_bgnt;
    logic dut_bgnt;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reload();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 6; c++)
                model_map[r][c] = 1'b1;
        model_cnt    = 48;
        model_starve = 0;
    endtask

    task automatic model_accept(input bit is_ball, input int x, input int row, input bit clr);
        exp_t e;
        int col;
        col      = x / 12;
        e.acc    = cyc;
        e.is_ball = is_ball;
        e.rem    = x % 12;
        e.hit    = (row < 8 && col < 6) ? model_map[row][col] : 1'b0;
        if (is_ball && clr && e.hit) begin
            model_map[row][col] = 1'b0;
            model_cnt--;
        end
        e.cnt = model_cnt;
        q.push_back(e);
    endtask

    // Called at posedge+1 with inputs already driven; checks grants, updates
    // the model, and returns at posedge+1 of the next cycle.
    task automatic cycle_go();
        bit ev, eb;
        #1;
        ev = 1'b0;
        eb = 1'b0;
        if (!(reset || init)) begin
            if (ball_req && (!vid_req || model_starve >= 3)) eb = 1'b1;
            else if (vid_req) ev = 1'b1;
        end
        chk("vid_gnt", vid_gnt, ev);
        chk("ball_gnt", ball_gnt, eb);
        dut_bgnt = ball_gnt;
        if (ev) model_accept(1'b0, vid_x, vid_row, 1'b0);
        if (eb) model_accept(1'b1, ball_x, ball_row, ball_clear);
        if (ball_req && !eb) model_starve = (model_starve < 3) ? model_starve + 1 : 3;
        else model_starve = 0;
        if (reset || init) begin
            model_reload();
            while (q.size() > 0 && q[$].acc >= cyc - 1) void'(q.pop_back());
        end
        exp_vgnt = ev;
        exp_bgnt = eb;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].acc + 2 < cyc) begin
            e = q.pop_front();
            chk("missing_valid", 32'd0, 32'd1);
        end
        if (vid_valid === 1'b1 || ball_valid === 1'b1) begin
            if (vid_valid === 1'b1 && ball_valid === 1'b1) chk("both_valid", 32'd1, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("latency", cyc - e.acc, 32'd2);
                chk("valid_kind", ball_valid, e.is_ball);
                if (e.is_ball) begin
                    chk("ball_hit", ball_hit, e.hit);
                end else begin
                    chk("vid_brick", vid_brick, e.hit);
                    chk("vid_rem", vid_rem, e.rem);
                end
                chk("bricks_left", bricks_left, e.cnt);
                chk("all_clear", all_clear, e.cnt == 0);
            end
        end
    end

    initial begin
        int first_b;
        reset = 1'b1; init = 1'b0;
        vid_req = 1'b1; vid_x = 6'd5; vid_row = 3'd1;
        ball_req = 1'b1; ball_x = 6'd7; ball_row = 3'd0; ball_clear = 1'b1;
        model_reload();
        @(posedge clk);
        #1;
        // Reset with both requests high: no grants.
        for (int i = 0; i < 3; i++) cycle_go();
        reset = 1'b0; vid_req = 1'b0; ball_req = 1'b0; ball_clear = 1'b0;
        cycle_go();
        chk("rst_bricks_left", bricks_left, 32'd48);
        chk("rst_all_clear", all_clear, 32'd0);
        chk("rst_vid_valid", vid_valid, 32'd0);
        chk("rst_ball_valid", ball_valid, 32'd0);

        // Video lookup 37/row 2: brick present, remainder 1.
        vid_req = 1'b1; vid_x = 6'd37; vid_row = 3'd2;
        cycle_go();
        vid_req = 1'b0;
        for (int i = 0; i < 3; i++) cycle_go();

        // Ball clears 37/row 2, video reads the same cell the next cycle.
        ball_req = 1'b1; ball_x = 6'd37; ball_row = 3'd2; ball_clear = 1'b1;
        cycle_go();
        ball_req = 1'b0;
        vid_req = 1'b1; vid_x = 6'd37; vid_row = 3'd2;
        cycle_go();
        vid_req = 1'b0;
        cycle_go();
        cycle_go();
        // Second clear of the same cell: miss, no decrement.
        ball_req = 1'b1;
        cycle_go();
        ball_req = 1'b0;
        for (int i = 0; i < 3; i++) cycle_go();
        chk("after_double_clear", bricks_left, 32'd47);

        // Starvation: both held high, ball must win on the 4th cycle.
        vid_req = 1'b1; vid_x = 6'd20; vid_row = 3'd4;
        ball_req = 1'b1; ball_x = 6'd3; ball_row = 3'd0; ball_clear = 1'b0;
        first_b = -1;
        for (int i = 0; i < 8; i++) begin
            cycle_go();
            if (dut_bgnt === 1'b1 && first_b < 0) first_b = i;
            if (exp_vgnt) vid_x = 6'($urandom_range(0, 63));
        end
        chk("starve_grant_cycle", first_b, 32'd3);
        vid_req = 1'b0; ball_req = 1'b0;
        for (int i = 0; i < 3; i++) cycle_go();

        // Clear every cell back-to-back.
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 6; c++) begin
                ball_req = 1'b1; ball_clear = 1'b1; ball_row = 3'(r);
                ball_x = 6'(c * 12 + $urandom_range(0, (c == 5) ? 3 : 11));
                cycle_go();
            end
        end
        ball_req = 1'b0; ball_clear = 1'b0;
        chk("last_minus1_left", bricks_left, 32'd1);
        chk("last_minus1_clear", all_clear, 32'd0);
        cycle_go();
        chk("all_gone_left", bricks_left, 32'd0);
        chk("all_gone_clear", all_clear, 32'd1);
        // Clear on an empty board: no underflow.
        ball_req = 1'b1; ball_clear = 1'b1; ball_x = 6'd0; ball_row = 3'd0;
        cycle_go();
        ball_req = 1'b0;
        for (int i = 0; i < 3; i++) cycle_go();
        chk("no_underflow", bricks_left, 32'd0);

        // Init with a lookup in flight: it is discarded.
        vid_req = 1'b1; vid_x = 6'd10; vid_row = 3'd1;
        cycle_go();
        vid_req = 1'b0; init = 1'b1;
        cycle_go();
        init = 1'b0;
        chk("init_left", bricks_left, 32'd48);
        chk("init_all_clear", all_clear, 32'd0);
        for (int i = 0; i < 2; i++) begin
            chk("init_vid_valid", vid_valid, 32'd0);
            chk("init_ball_valid", ball_valid, 32'd0);
            cycle_go();
        end

        // Randomized traffic with occasional init.
        for (int i = 0; i < 600; i++) begin
            if (!vid_req || exp_vgnt) begin
                vid_req = ($urandom_range(0, 9) < 6);
                vid_x   = 6'($urandom_range(0, 63));
                vid_row = 3'($urandom_range(0, 7));
            end
            if (!ball_req || exp_bgnt) begin
                ball_req   = ($urandom_range(0, 9) < 7);
                ball_x     = 6'($urandom_range(0, 63));
                ball_row   = 3'($urandom_range(0, 7));
                ball_clear = ($urandom_range(0, 3) != 0);
            end
            init = ($urandom_range(0, 79) == 0);
            cycle_go();
        end
        init = 1'b0; vid_req = 1'b0; ball_req = 1'b0;
        for (int i = 0; i < 4; i++) cycle_go();
        chk("queue_drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
